// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter in front of a single burst-read memory port.
// One burst at a time: grant, forward beats to the owner, then a one-cycle release gap.
module mem_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              m0_rreq,
  input  logic [ADDR_W-1:0] m0_raddr,
  input  logic [1:0]        m0_burst_len,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_rvalid,
  output logic              m0_rlast,

  input  logic              m1_rreq,
  input  logic [ADDR_W-1:0] m1_raddr,
  input  logic [1:0]        m1_burst_len,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_rvalid,
  output logic              m1_rlast,

  output logic              mem_rreq,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic [1:0]        mem_burst_len,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  input  logic              mem_rlast,

  output logic [1:0]        grant,
  output logic              proto_err
);

  typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

  state_t     state;
  logic [1:0] owner;     // one-hot: bit0 = m0, bit1 = m1
  logic       rr;        // 0 prefers m0, 1 prefers m1 on contention
  logic [1:0] beat_cnt;
  logic       busy;
  logic       pick_m1;

  assign busy    = (state == BUSY);
  assign pick_m1 = m1_rreq & (~m0_rreq | rr);
  assign grant   = owner;

  // Beat data is shared; only the owner sees valid/last, and only while a burst is open.
  assign m0_rdata  = mem_rdata;
  assign m1_rdata  = mem_rdata;
  assign m0_rvalid = busy & owner[0] & mem_rvalid;
  assign m0_rlast  = busy & owner[0] & mem_rvalid & mem_rlast;
  assign m1_rvalid = busy & owner[1] & mem_rvalid;
  assign m1_rlast  = busy & owner[1] & mem_rvalid & mem_rlast;

  // NOTE: all state below updates with non-blocking assignments so every register
  // samples the pre-edge values of its peers, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      owner         <= 2'b00;
      rr            <= 1'b0;
      beat_cnt      <= 2'd0;
      mem_rreq      <= 1'b0;
      mem_raddr     <= '0;
      mem_burst_len <= 2'd0;
      proto_err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (m0_rreq || m1_rreq) begin
            state    <= BUSY;
            mem_rreq <= 1'b1;
            beat_cnt <= 2'd0;
            if (pick_m1) begin
              owner         <= 2'b10;
              mem_raddr     <= m1_raddr;
              mem_burst_len <= m1_burst_len;
            end else begin
              owner         <= 2'b01;
              mem_raddr     <= m0_raddr;
              mem_burst_len <= m0_burst_len;
            end
          end
        end

        BUSY: begin
          if (mem_rvalid) begin
            beat_cnt <= beat_cnt + 2'd1;
            // rlast must coincide exactly with the beat whose count equals burst_len.
            if (mem_rlast != (beat_cnt == mem_burst_len))
              proto_err <= 1'b1;
            if (mem_rlast) begin
              state    <= RELEASE;
              mem_rreq <= 1'b0;
              owner    <= 2'b00;
              rr       <= owner[0];
            end
          end
        end

        RELEASE: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: the bench plays both requesters and the burst memory,
// and a scoreboard queue holds each beat's expected destination, data and last flag.
module tb_mem_arbiter;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              m0_rreq, m1_rreq;
  logic [ADDR_W-1:0] m0_raddr, m1_raddr;
  logic [1:0]        m0_burst_len, m1_burst_len;
  logic [DATA_W-1:0] m0_rdata, m1_rdata;
  logic              m0_rvalid, m1_rvalid, m0_rlast, m1_rlast;
  logic              mem_rreq;
  logic [ADDR_W-1:0] mem_raddr;
  logic [1:0]        mem_burst_len;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_rvalid, mem_rlast;
  logic [1:0]        grant;
  logic              proto_err;

  typedef struct {
    logic [1:0]        who;
    logic [DATA_W-1:0] data;
    logic              last;
  } beat_t;

  beat_t sb_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
    .m0_rreq(m0_rreq), .m0_raddr(m0_raddr), .m0_burst_len(m0_burst_len),
    .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid), .m0_rlast(m0_rlast),
    .m1_rreq(m1_rreq), .m1_raddr(m1_raddr), .m1_burst_len(m1_burst_len),
    .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid), .m1_rlast(m1_rlast),
    .mem_rreq(mem_rreq), .mem_raddr(mem_raddr), .mem_burst_len(mem_burst_len),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .mem_rlast(mem_rlast),
    .grant(grant), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory side: drive n beats back to back, rlast on beat index last_at.
  task automatic mem_beats(input logic [1:0] who, input int n, input int last_at);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = DATA_W'($urandom);
      mem_rlast  = (i == last_at);
      b.who  = who;
      b.data = mem_rdata;
      b.last = mem_rlast;
      sb_q.push_back(b);
      tick();
    end
    mem_rvalid = 1'b0;
    mem_rlast  = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    check("rst_grant", grant, 2'b00);
    check("rst_mem_rreq", mem_rreq, 1'b0);
    check("rst_mem_raddr", mem_raddr, '0);
    check("rst_mem_len", mem_burst_len, 2'd0);
    check("rst_proto_err", proto_err, 1'b0);
    reset = 1'b1;
  endtask

  // Output monitor: every forwarded beat must match the head of the scoreboard.
  always @(negedge clk) begin
    if (m0_rvalid || m1_rvalid) begin
      if (sb_q.size() == 0) begin
        check("unexpected_rvalid", {m1_rvalid, m0_rvalid}, 2'b00);
      end else begin
        beat_t e;
        e = sb_q.pop_front();
        check("beat_owner", {m1_rvalid, m0_rvalid}, e.who);
        check("beat_data", m0_rvalid ? m0_rdata : m1_rdata, e.data);
        check("beat_last", {m1_rlast, m0_rlast}, e.last ? e.who : 2'b00);
      end
    end
  end

  initial begin
    int gap;
    reset = 1'b0;
    m0_rreq = 0; m1_rreq = 0;
    m0_raddr = '0; m1_raddr = '0;
    m0_burst_len = 0; m1_burst_len = 0;
    mem_rdata = '0; mem_rvalid = 0; mem_rlast = 0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Single master, 4-beat burst.
    m0_rreq = 1; m0_raddr = 10'h040; m0_burst_len = 2'd3;
    #1 check("t1_rreq_not_yet", mem_rreq, 1'b0);
    tick();
    check("t1_mem_rreq", mem_rreq, 1'b1);
    check("t1_mem_raddr", mem_raddr, 10'h040);
    check("t1_mem_len", mem_burst_len, 2'd3);
    check("t1_grant", grant, 2'b01);
    mem_beats(2'b01, 4, 3);
    m0_rreq = 0;
    check("t1_grant_clear", grant, 2'b00);
    check("t1_rreq_drop", mem_rreq, 1'b0);
    check("t1_proto_ok", proto_err, 1'b0);
    tick();

    // Contention from reset: m0, then m1, then m0 again.
    do_reset();
    m0_rreq = 1; m0_raddr = 10'h100; m0_burst_len = 2'd1;
    m1_rreq = 1; m1_raddr = 10'h200; m1_burst_len = 2'd0;
    tick();
    check("t2_grant_m0", grant, 2'b01);
    check("t2_addr_m0", mem_raddr, 10'h100);
    mem_beats(2'b01, 2, 1);
    m0_rreq = 0;
    check("t2_release_grant", grant, 2'b00);
    tick();
    check("t2_idle_rreq", mem_rreq, 1'b0);
    tick();
    check("t2_grant_m1", grant, 2'b10);
    check("t2_addr_m1", mem_raddr, 10'h200);
    check("t2_len_m1", mem_burst_len, 2'd0);
    mem_beats(2'b10, 1, 0);
    tick();
    m0_rreq = 1; m0_raddr = 10'h111;
    tick();
    check("t2_alternate_m0", grant, 2'b01);
    check("t2_alt_addr", mem_raddr, 10'h111);
    mem_beats(2'b01, 2, 1);
    m0_rreq = 0; m1_rreq = 0;
    tick();

    // Early drop by m1: request held constant at the memory anyway.
    m1_rreq = 1; m1_raddr = 10'h155; m1_burst_len = 2'd1;
    tick();
    check("t3_grant_m1", grant, 2'b10);
    m1_rreq = 0; m1_raddr = 10'h3ff; m1_burst_len = 2'd3;
    tick();
    check("t3_rreq_held", mem_rreq, 1'b1);
    check("t3_addr_held", mem_raddr, 10'h155);
    check("t3_len_held", mem_burst_len, 2'd1);
    mem_beats(2'b10, 2, 1);
    check("t3_rreq_low", mem_rreq, 1'b0);
    tick();
    tick();
    check("t3_stay_idle", mem_rreq, 1'b0);

    // Short burst: rlast on beat 2 of 4.
    m0_rreq = 1; m0_raddr = 10'h080; m0_burst_len = 2'd3;
    tick();
    check("t4_err_before", proto_err, 1'b0);
    mem_beats(2'b01, 2, 1);
    m0_rreq = 0;
    check("t4_err_set", proto_err, 1'b1);
    check("t4_released", grant, 2'b00);
    tick();
    tick();
    check("t4_err_sticky", proto_err, 1'b1);

    // Missing rlast: beat with count == burst_len but no rlast.
    do_reset();
    m1_rreq = 1; m1_raddr = 10'h020; m1_burst_len = 2'd0;
    tick();
    mem_beats(2'b10, 1, 5);
    check("t4b_err_no_last", proto_err, 1'b1);
    check("t4b_still_busy", grant, 2'b10);
    mem_beats(2'b10, 1, 0);
    m1_rreq = 0;
    tick();

    // Stray memory beat while idle is ignored.
    do_reset();
    mem_rvalid = 1; mem_rlast = 1; mem_rdata = 8'h5a;
    #1 check("t5_no_forward", {m1_rvalid, m0_rvalid}, 2'b00);
    tick();
    mem_rvalid = 0; mem_rlast = 0;
    check("t5_idle_grant", grant, 2'b00);
    check("t5_idle_rreq", mem_rreq, 1'b0);
    check("t5_idle_err", proto_err, 1'b0);

    // Reset during beat 2 of 4, then a fresh m1 request.
    m0_rreq = 1; m0_raddr = 10'h300; m0_burst_len = 2'd3;
    tick();
    mem_beats(2'b01, 1, 3);
    mem_rvalid = 1; mem_rdata = 8'ha5;
    #1 reset = 1'b0;
    #1;
    check("t6_rst_rvalid", {m1_rvalid, m0_rvalid}, 2'b00);
    check("t6_rst_grant", grant, 2'b00);
    check("t6_rst_rreq", mem_rreq, 1'b0);
    check("t6_rst_addr", mem_raddr, '0);
    check("t6_rst_len", mem_burst_len, 2'd0);
    check("t6_rst_err", proto_err, 1'b0);
    mem_rvalid = 0;
    m0_rreq = 0;
    tick();
    reset = 1'b1;
    m1_rreq = 1; m1_raddr = 10'h0c4; m1_burst_len = 2'd2;
    tick();
    check("t6_regrant", grant, 2'b10);
    check("t6_regrant_addr", mem_raddr, 10'h0c4);
    mem_beats(2'b10, 3, 2);
    m1_rreq = 0;
    check("t6_err_clean", proto_err, 1'b0);
    tick();
    tick();

    // Back-to-back bursts from m0 with its request held high.
    m0_rreq = 1; m0_raddr = 10'h010; m0_burst_len = 2'd0;
    tick();
    for (int k = 0; k < 2; k++) begin
      check("t7_grant", grant, 2'b01);
      mem_beats(2'b01, 1, 0);
      gap = 0;
      while (!mem_rreq && gap < 10) begin
        gap++;
        tick();
      end
      check("t7_gap_cycles", gap, 2);
    end
    mem_beats(2'b01, 1, 0);
    m0_rreq = 0;
    tick();
    tick();

    check("sb_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
